// File: rtl/parking_event_logger_if.sv
// Read-side bus of the parking event logger: record head, occupancy and overflow
// flag toward the reader; pop request and overflow clear toward the logger.
interface parking_event_logger_if #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 12
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a record transfers on a rising edge where rec_valid && rd_req;
  // rd_req while rec_valid = 0 is ignored, and rec_data holds the head
  // record for as long as rec_valid stays high.
  logic              rd_req;
  logic              clear_ovf;
  logic              rec_valid;
  logic [TS_W+4:0]   rec_data;
  logic [CW-1:0]     count;
  logic              overflow;

  modport master (
    output rd_req, clear_ovf,
    input  rec_valid, rec_data, count, overflow
  );

  modport slave (
    input  rd_req, clear_ovf,
    output rec_valid, rec_data, count, overflow
  );
endinterface

// File: rtl/parking_event_logger.sv
// Samples the parking FSM state and door pulse, timestamps every change or pulse,
// and queues the records in a show-ahead FIFO drained through the read bus.
module parking_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  state,
  input  logic                        door_open_pulse,
  parking_event_logger_if.slave       bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = TS_W + 5;

  logic [TS_W-1:0]  ts;
  logic [3:0]       prev_state;
  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic event_hit;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    event_hit = (state != prev_state) || door_open_pulse;
    full      = (cnt == CW'(DEPTH));
    pop       = bus.rd_req && (cnt != '0);
    // A pop on the same edge frees the slot the new record needs.
    push      = event_hit && (!full || pop);
    drop      = event_hit && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      prev_state <= 4'b0000;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ts         <= ts + TS_W'(1);
      prev_state <= state;

      if (push) begin
        mem[wr_ptr] <= {ts, state, door_open_pulse};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        ovf <= 1'b1;
      end else if (bus.clear_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus.rec_valid = (cnt != '0);
  assign bus.rec_data  = mem[rd_ptr];
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_parking_event_logger.sv
// Scenario bench for parking_event_logger: a reference model feeds an expected
// record queue that is compared against the FIFO head as records are drained.
module tb_parking_event_logger;
  localparam int DEPTH = 8;
  localparam int TS_W  = 4;
  localparam int REC_W = TS_W + 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = 4'b0000;
  logic       door_open_pulse = 1'b0;

  always #5 clk = ~clk;

  parking_event_logger_if #(.DEPTH(DEPTH), .TS_W(TS_W)) bus ();

  parking_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .state           (state),
    .door_open_pulse (door_open_pulse),
    .bus             (bus.slave)
  );

  // scoreboard and reference model
  logic [REC_W-1:0] exp_q[$];
  logic [TS_W-1:0]  m_ts;
  logic [3:0]       m_prev;
  logic             m_ovf;
  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    exp_q.delete();
    m_ts   = '0;
    m_prev = 4'b0000;
    m_ovf  = 1'b0;
  endtask

  task automatic do_reset();
    state           = 4'b0000;
    door_open_pulse = 1'b0;
    bus.rd_req      = 1'b0;
    bus.clear_ovf   = 1'b0;
    rst_n           = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, let one edge pass, and advance the model.
  task automatic drive_cycle(input logic [3:0] st, input logic door,
                             input logic rd, input logic clr);
    logic ev, pop, full;
    state           = st;
    door_open_pulse = door;
    bus.rd_req      = rd;
    bus.clear_ovf   = clr;
    ev   = (st != m_prev) || door;
    pop  = rd && (exp_q.size() > 0);
    full = (exp_q.size() == DEPTH);
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (ev && (!full || pop)) exp_q.push_back({m_ts, st, door});
    if (ev && full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev = st;
    m_ts   = m_ts + 1'b1;
    #1;
    door_open_pulse = 1'b0;
    bus.rd_req      = 1'b0;
    bus.clear_ovf   = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (bus.rec_valid !== 1'b0 || bus.count !== '0 || bus.overflow !== 1'b0 ||
        bus.rec_data !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%b count=%0d ovf=%b data=%h, want 0/0/0/0",
               bus.rec_valid, bus.count, bus.overflow, bus.rec_data);
    end
    do_reset();
  endtask

  task automatic test_single_change();
    logic [REC_W-1:0] want;
    for (int i = 0; i < 5; i++) drive_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'b0011, 1'b0, 1'b0, 1'b0);
    want = {4'd5, 4'b0011, 1'b0};
    total++;
    if (bus.rec_valid !== 1'b1 || bus.rec_data !== want || bus.count !== CW'(1)) begin
      bad++;
      $display("FAIL single_record: valid=%b data=%h count=%0d, want 1/%h/1",
               bus.rec_valid, bus.rec_data, bus.count, want);
    end
    for (int i = 0; i < 3; i++) drive_cycle(4'b0011, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.count !== CW'(1)) begin
      bad++;
      $display("FAIL stable_no_event: count=%0d, want 1", bus.count);
    end
    total++;
    if (bus.rec_data !== exp_q[0]) begin
      bad++;
      $display("FAIL single_pop: data=%h, want %h", bus.rec_data, exp_q[0]);
    end
    drive_cycle(4'b0011, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus.rec_valid !== 1'b0 || bus.count !== '0) begin
      bad++;
      $display("FAIL single_drained: valid=%b count=%0d, want 0/0", bus.rec_valid, bus.count);
    end
  endtask

  task automatic test_door_pulse();
    drive_cycle(4'b0011, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.count !== CW'(1) || bus.rec_data[0] !== 1'b1 || bus.rec_data[4:1] !== 4'b0011) begin
      bad++;
      $display("FAIL door_only: count=%0d data=%h, want count 1 state 3 door 1",
               bus.count, bus.rec_data);
    end
    drive_cycle(4'b0110, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.count !== CW'(2) || bus.count !== CW'(exp_q.size())) begin
      bad++;
      $display("FAIL coincident_one_record: count=%0d, want 2", bus.count);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.rec_data !== exp_q[0]) begin
        bad++;
        $display("FAIL door_drain: data=%h, want %h", bus.rec_data, exp_q[0]);
      end
      drive_cycle(4'b0110, 1'b0, 1'b1, 1'b0);
    end
    // empty FIFO with event and read request: push only
    drive_cycle(4'b0110, 1'b1, 1'b1, 1'b0);
    total++;
    if (bus.count !== CW'(1) || bus.rec_data !== exp_q[0]) begin
      bad++;
      $display("FAIL empty_event_rd: count=%0d data=%h, want 1/%h",
               bus.count, bus.rec_data, exp_q[0]);
    end
    drive_cycle(4'b0110, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    logic [REC_W-1:0] first_rec;
    logic [REC_W-1:0] second_rec;
    logic [REC_W-1:0] new_rec;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) first_rec = {m_ts, 4'ha, 1'b0};
      drive_cycle((i % 2 == 0) ? 4'ha : 4'h9, 1'b0, 1'b0, 1'b0);
    end
    total++;
    if (bus.count !== CW'(DEPTH) || bus.overflow !== 1'b1 || bus.rec_data !== first_rec) begin
      bad++;
      $display("FAIL overflow_full: count=%0d ovf=%b head=%h, want 8/1/%h",
               bus.count, bus.overflow, bus.rec_data, first_rec);
    end
    // drop coinciding with clear: flag stays set
    drive_cycle(4'h5, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.overflow !== 1'b1 || bus.count !== CW'(DEPTH)) begin
      bad++;
      $display("FAIL drop_beats_clear: ovf=%b count=%0d, want 1/8", bus.overflow, bus.count);
    end
    drive_cycle(4'h5, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL clear_ovf: ovf=%b, want 0", bus.overflow);
    end
    // full with simultaneous event and pop
    second_rec = exp_q[1];
    new_rec    = {m_ts, 4'hc, 1'b0};
    drive_cycle(4'hc, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus.count !== CW'(DEPTH) || bus.overflow !== 1'b0 || bus.rec_data !== second_rec) begin
      bad++;
      $display("FAIL full_push_pop: count=%0d ovf=%b head=%h, want 8/0/%h",
               bus.count, bus.overflow, bus.rec_data, second_rec);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bus.rec_valid !== 1'b1 || bus.rec_data !== exp_q[0]) begin
        bad++;
        $display("FAIL overflow_order[%0d]: valid=%b data=%h, want 1/%h",
                 i, bus.rec_valid, bus.rec_data, exp_q[0]);
      end
      if (i == DEPTH - 1) begin
        total++;
        if (bus.rec_data !== new_rec) begin
          bad++;
          $display("FAIL tail_record: data=%h, want %h", bus.rec_data, new_rec);
        end
      end
      drive_cycle(4'hc, 1'b0, 1'b1, 1'b0);
    end
    total++;
    if (bus.rec_valid !== 1'b0 || bus.count !== '0) begin
      bad++;
      $display("FAIL overflow_drained: valid=%b count=%0d, want 0/0", bus.rec_valid, bus.count);
    end
  endtask

  task automatic test_wrap_drain();
    logic [3:0] st;
    for (int i = 0; i < 20; i++) begin
      st = (i % 2 == 0) ? 4'h7 : 4'h2;
      if (exp_q.size() > 0) begin
        total++;
        if (bus.rec_data !== exp_q[0]) begin
          bad++;
          $display("FAIL stream_data[%0d]: data=%h, want %h", i, bus.rec_data, exp_q[0]);
        end
      end
      drive_cycle(st, 1'b0, 1'b1, 1'b0);
      total++;
      if (bus.count > CW'(1) || bus.count !== CW'(exp_q.size())) begin
        bad++;
        $display("FAIL stream_count[%0d]: count=%0d, want %0d (<=1)", i, bus.count, exp_q.size());
      end
    end
    total++;
    if (bus.rec_data !== exp_q[0]) begin
      bad++;
      $display("FAIL stream_last: data=%h, want %h", bus.rec_data, exp_q[0]);
    end
    drive_cycle(m_prev, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ts_wrap();
    logic [REC_W-1:0] want;
    do_reset();
    for (int i = 0; i < 15; i++) drive_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'b0001, 1'b0, 1'b0, 1'b0);
    want = {4'd15, 4'b0001, 1'b0};
    total++;
    if (bus.rec_data !== want) begin
      bad++;
      $display("FAIL ts_15: data=%h, want %h", bus.rec_data, want);
    end
    drive_cycle(4'b0010, 1'b0, 1'b1, 1'b0);
    want = {4'd0, 4'b0010, 1'b0};
    total++;
    if (bus.rec_data !== want || bus.count !== CW'(1)) begin
      bad++;
      $display("FAIL ts_wrap_0: data=%h count=%0d, want %h/1", bus.rec_data, bus.count, want);
    end
    drive_cycle(4'b0010, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [REC_W-1:0] want;
    drive_cycle(4'h3, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'h4, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'h5, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.count !== CW'(3)) begin
      bad++;
      $display("FAIL prefill: count=%0d, want 3", bus.count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rec_valid !== 1'b0 || bus.count !== '0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: valid=%b count=%0d ovf=%b, want 0/0/0",
               bus.rec_valid, bus.count, bus.overflow);
    end
    do_reset();
    drive_cycle(4'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'h9, 1'b0, 1'b0, 1'b0);
    want = {4'd2, 4'h9, 1'b0};
    total++;
    if (bus.rec_data !== want || bus.count !== CW'(1)) begin
      bad++;
      $display("FAIL ts_restart: data=%h count=%0d, want %h/1", bus.rec_data, bus.count, want);
    end
  endtask

  initial begin
    bus.rd_req    = 1'b0;
    bus.clear_ovf = 1'b0;
    model_reset();
    test_reset();
    test_single_change();
    test_door_pulse();
    test_overflow();
    test_wrap_drain();
    test_ts_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
